nmed_sweep_ctrl: RTL
====================

// Module: nmed_sweep_ctrl
// PURPOSE
// - Hardware sequencer that characterises an approximate multiplier against the exact multiplier.
// - Sweeps every signed WIDTH x WIDTH operand pair into both multipliers and accumulates the
//   error statistics that NMED/MED reporting needs. Software forms NMED = err_sum/(pair_cnt*max_exact).
// - Sits between the shared operand bus and the exact_mult / approximate multiplier pair.
//   Both multipliers are combinational; both are driven from o_a/o_b.
// PARAMETERS
// - WIDTH   8                        operand width; products are 2*WIDTH signed
// - CNT_W   2*WIDTH+1                pair/error counter width; holds 2^(2*WIDTH)
// - SUM_W   4*WIDTH                  absolute-error accumulator width, unsigned
// PORTS
// - i_clk        in   1        clock
// - i_rst        in   1        asynchronous, active-high reset
// - i_start      in   1        start a sweep; accepted only in IDLE or DONE
// - i_abort      in   1        cancel a sweep in progress
// - o_a          out  WIDTH    operand A to both multipliers (signed)
// - o_b          out  WIDTH    operand B to both multipliers (signed)
// - i_z_exact    in   2*WIDTH  exact product of o_a*o_b (signed)
// - i_z_approx   in   2*WIDTH  approximate product of o_a*o_b (signed)
// - o_busy       out  1        high in SWEEP and DRAIN
// - o_done       out  1        level; high in DONE until the next accepted start or reset
// - o_pair_cnt   out  CNT_W    number of pairs accumulated
// - o_err_cnt    out  CNT_W    number of pairs with approx != exact
// - o_err_sum    out  SUM_W    sum of |approx - exact|
// - o_max_err    out  2*WIDTH  max |approx - exact|, unsigned
// - o_max_exact  out  2*WIDTH  max signed exact product (the NMED normaliser)
// BEHAVIOUR
// - Reset: state IDLE; every output 0. Reset mid-sweep discards all partial results.
// - FSM states and transitions:
//   IDLE -> SWEEP on i_start.
//   SWEEP -> DRAIN when the last pair is issued.
//   DRAIN -> DONE after 2 cycles.
//   DONE -> SWEEP on i_start.
//   SWEEP/DRAIN -> IDLE on i_abort. Abort takes priority over completion in the same cycle.
//   After abort, o_done stays 0 and statistics hold their partial values.
// - Accepting i_start clears every statistic and sets o_a = o_b = 0 in the same edge.
//   i_start is ignored in SWEEP and DRAIN.
// - Issue order:
//   - One pair per cycle. Raw bit pattern 0..2^WIDTH-1, B is the inner loop and A the outer loop.
//   - Sequence: (0,0), (0,1) ... (0,-1), (1,0) ... (-1,-1). Both operands wrap naturally.
//   - The sweep issues 2^(2*WIDTH) pairs exactly.
// - Pipeline, with a valid bit per stage:
//   - Stage 0: o_a/o_b registered; products sampled at the end of the same cycle.
//   - Stage 1: register diff = approx - exact, sign-extended to 2*WIDTH+1 bits. Register |diff|.
//     |diff| is never truncated, so -2^(2W-1) - (2^(2W-1)-1) is handled.
//   - Stage 2: update pair_cnt, err_cnt, err_sum, max_err and max_exact.
// - Results are final 2 cycles after the last issue.
//   Total sweep time is 2^(2*WIDTH) + 2 cycles from the start edge to o_done.
// - max_exact uses a signed compare and starts from 0. A negative-only product set yields 0.
// - err_sum saturates at all-ones. No wrap is permitted for SUM_W < 4*WIDTH.
// - o_a/o_b hold their last value in DRAIN and DONE, and return to 0 in IDLE.
// STRUCTURE
// - Package nmed_pkg:
//   - state enum {IDLE, SWEEP, DRAIN, DONE}
//   - localparams PROD_W = 2*WIDTH, DIFF_W = 2*WIDTH+1
//   - function for saturating add
// - Sub-module nmed_err_accum: stages 1-2 (abs-diff plus statistics), with in_valid and clear inputs.
//   The top holds the FSM, the operand counters and the valid pipeline.
// TESTING
// - Run with WIDTH=8; tie both product inputs to an exact multiplier.
//   -> err_sum=0, err_cnt=0, max_err=0, max_exact=16384, pair_cnt=65536.
//   -> o_done rises exactly 65538 cycles after the start edge.
// - Tie approx to 0.
//   -> err_sum=268435456, err_cnt=65025, max_err=16384, max_exact=16384.
// - Set approx = exact+1.
//   -> err_sum=65536, err_cnt=65536, max_err=1.
// - Run with WIDTH=4; assert i_abort at cycle 100.
//   -> Next edge goes to IDLE; o_done=0; pair_cnt stops at 98 (pipeline drains are discarded).
// - Pulse i_start mid-sweep.
//   -> Ignored. Reassert i_start in DONE: statistics clear and a full sweep is repeated.
//   Assert i_rst mid-sweep: all outputs 0 asynchronously.
// - Run with WIDTH=4, approx = exact, checked against a bench scoreboard.
//   -> The issued (o_a,o_b) sequence matches the nested-loop order.
//   -> The last pair is (-1,-1); max_exact=64.

Source files
------------

// File: rtl/nmed_pkg.sv
// Shared types and helpers for the approximate-multiplier error sweep sequencer.
package nmed_pkg;

    typedef enum logic [1:0] {IDLE, SWEEP, DRAIN, DONE} state_e;

    localparam int NMED_WIDTH = 8;

    // Unsigned add clamped to the all-ones value of a w-bit field (w <= 64).
    function automatic logic [63:0] sat_add(input logic [63:0] a, input logic [63:0] b,
                                            input int unsigned w);
        logic [64:0] sum;
        logic [64:0] lim;
        sum = {1'b0, a} + {1'b0, b};
        lim = (65'd1 << w) - 65'd1;
        return (sum > lim) ? lim[63:0] : sum[63:0];
    endfunction

endpackage

// File: rtl/nmed_err_accum.sv
// Error pipeline: stage 1 forms the signed difference and its magnitude, stage 2
// folds it into the sweep statistics.
module nmed_err_accum
    import nmed_pkg::*;
#(
    parameter int WIDTH = NMED_WIDTH,
    parameter int CNT_W = 2*WIDTH+1,
    parameter int SUM_W = 4*WIDTH
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_in_valid,
    input  logic               i_clear,
    input  logic               i_flush,
    input  logic [2*WIDTH-1:0] i_z_exact,
    input  logic [2*WIDTH-1:0] i_z_approx,
    output logic [CNT_W-1:0]   o_pair_cnt,
    output logic [CNT_W-1:0]   o_err_cnt,
    output logic [SUM_W-1:0]   o_err_sum,
    output logic [2*WIDTH-1:0] o_max_err,
    output logic [2*WIDTH-1:0] o_max_exact
);
    localparam int PROD_W = 2*WIDTH;
    localparam int DIFF_W = PROD_W+1;

    logic                     v1_q;
    logic signed [DIFF_W-1:0] diff_q, diff_d;
    logic [DIFF_W-1:0]        abs_q, abs_d;
    logic [PROD_W-1:0]        exact_q;
    logic [CNT_W-1:0]         pair_cnt_q, pair_cnt_d, err_cnt_q, err_cnt_d;
    logic [SUM_W-1:0]         err_sum_q, err_sum_d;
    logic [PROD_W-1:0]        max_err_q, max_err_d, max_exact_q, max_exact_d;

    // One extra bit keeps the full magnitude of the widest possible difference.
    always_comb begin
        diff_d = $signed({i_z_approx[PROD_W-1], i_z_approx}) - $signed({i_z_exact[PROD_W-1], i_z_exact});
        abs_d  = diff_d[DIFF_W-1] ? -diff_d : diff_d;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            v1_q    <= 1'b0;
            diff_q  <= '0;
            abs_q   <= '0;
            exact_q <= '0;
        end else begin
            v1_q    <= i_in_valid & ~i_flush;
            diff_q  <= diff_d;
            abs_q   <= abs_d;
            exact_q <= i_z_exact;
        end
    end

    always_comb begin
        pair_cnt_d  = pair_cnt_q;
        err_cnt_d   = err_cnt_q;
        err_sum_d   = err_sum_q;
        max_err_d   = max_err_q;
        max_exact_d = max_exact_q;
        if (i_clear) begin
            pair_cnt_d  = '0;
            err_cnt_d   = '0;
            err_sum_d   = '0;
            max_err_d   = '0;
            max_exact_d = '0;
        end else if (v1_q && !i_flush) begin
            pair_cnt_d = pair_cnt_q + CNT_W'(1);
            if (diff_q != '0)
                err_cnt_d = err_cnt_q + CNT_W'(1);
            err_sum_d = SUM_W'(sat_add(64'(err_sum_q), 64'(abs_q), SUM_W));
            if (abs_q > {1'b0, max_err_q})
                max_err_d = abs_q[PROD_W-1:0];
            if ($signed(exact_q) > $signed(max_exact_q))
                max_exact_d = exact_q;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            pair_cnt_q  <= '0;
            err_cnt_q   <= '0;
            err_sum_q   <= '0;
            max_err_q   <= '0;
            max_exact_q <= '0;
        end else begin
            pair_cnt_q  <= pair_cnt_d;
            err_cnt_q   <= err_cnt_d;
            err_sum_q   <= err_sum_d;
            max_err_q   <= max_err_d;
            max_exact_q <= max_exact_d;
        end
    end

    assign o_pair_cnt  = pair_cnt_q;
    assign o_err_cnt   = err_cnt_q;
    assign o_err_sum   = err_sum_q;
    assign o_max_err   = max_err_q;
    assign o_max_exact = max_exact_q;

endmodule

// File: rtl/nmed_sweep_ctrl.sv
// Sweeps every signed operand pair into the exact/approximate multiplier pair and
// gathers the error statistics used for NMED/MED reporting.
//   state | meaning
//   IDLE  | no sweep; operands parked at 0
//   SWEEP | issuing one operand pair per cycle
//   DRAIN | last pair issued, error pipeline emptying (2 cycles)
//   DONE  | statistics final, o_done high
module nmed_sweep_ctrl
    import nmed_pkg::*;
#(
    parameter int WIDTH = NMED_WIDTH,
    parameter int CNT_W = 2*WIDTH+1,
    parameter int SUM_W = 4*WIDTH
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_start,
    input  logic               i_abort,
    output logic [WIDTH-1:0]   o_a,
    output logic [WIDTH-1:0]   o_b,
    input  logic [2*WIDTH-1:0] i_z_exact,
    input  logic [2*WIDTH-1:0] i_z_approx,
    output logic               o_busy,
    output logic               o_done,
    output logic [CNT_W-1:0]   o_pair_cnt,
    output logic [CNT_W-1:0]   o_err_cnt,
    output logic [SUM_W-1:0]   o_err_sum,
    output logic [2*WIDTH-1:0] o_max_err,
    output logic [2*WIDTH-1:0] o_max_exact
);
    localparam int PROD_W = 2*WIDTH;

    state_e            state_q, state_d;
    logic [PROD_W-1:0] idx_q, idx_d;
    logic              drain_q, drain_d;
    logic              v0_q, v0_d;
    logic              start_ok, abort_ok;

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        drain_d  = drain_q;
        v0_d     = 1'b0;
        start_ok = i_start && (state_q == IDLE || state_q == DONE);
        abort_ok = i_abort && (state_q == SWEEP || state_q == DRAIN);
        case (state_q)
            IDLE, DONE: begin
                if (i_start) begin
                    state_d = SWEEP;
                    idx_d   = '0;
                    v0_d    = 1'b1;
                end
            end
            SWEEP: begin
                // Abort wins over the last-pair transition.
                if (i_abort) begin
                    state_d = IDLE;
                    idx_d   = '0;
                end else if (&idx_q) begin
                    state_d = DRAIN;
                    drain_d = 1'b0;
                end else begin
                    idx_d = idx_q + PROD_W'(1);
                    v0_d  = 1'b1;
                end
            end
            DRAIN: begin
                if (i_abort) begin
                    state_d = IDLE;
                    idx_d   = '0;
                end else if (drain_q) begin
                    state_d = DONE;
                end else begin
                    drain_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            drain_q <= 1'b0;
            v0_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            drain_q <= drain_d;
            v0_q    <= v0_d;
        end
    end

    assign o_a    = idx_q[PROD_W-1:WIDTH];
    assign o_b    = idx_q[WIDTH-1:0];
    assign o_busy = (state_q == SWEEP) || (state_q == DRAIN);
    assign o_done = (state_q == DONE);

    nmed_err_accum #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W),
        .SUM_W (SUM_W)
    ) u_accum (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_in_valid  (v0_q),
        .i_clear     (start_ok),
        .i_flush     (abort_ok),
        .i_z_exact   (i_z_exact),
        .i_z_approx  (i_z_approx),
        .o_pair_cnt  (o_pair_cnt),
        .o_err_cnt   (o_err_cnt),
        .o_err_sum   (o_err_sum),
        .o_max_err   (o_max_err),
        .o_max_exact (o_max_exact)
    );

endmodule
